// File: rtl/network_run_source_pkg.sv
// Shared constants, packet field layout and FSM state type for the burst-mode network source.
package network_run_source_pkg;

    localparam int NUM_FLG          = 2;
    localparam int FLG_SNC          = 0;
    localparam int FLG_CLR          = 1;

    localparam int DEF_NUM_INP      = 2;
    localparam int DEF_CHARGE_WIDTH = 8;
    localparam int DEF_RUN_WIDTH    = 16;

    localparam int PFX_WIDTH        = NUM_FLG;
    localparam int RUN_WIDTH        = DEF_RUN_WIDTH;
    localparam int SPK_WIDTH        = DEF_NUM_INP * DEF_CHARGE_WIDTH;

    // Field offsets within a default-sized packet, charges in the low bits.
    localparam int SPK_OFS          = 0;
    localparam int RUN_OFS          = SPK_OFS + SPK_WIDTH;
    localparam int PFX_OFS          = RUN_OFS + RUN_WIDTH;
    localparam int PKT_WIDTH        = PFX_OFS + PFX_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN_FIRST,
        RUN_REST
    } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready FIFO with a registered ready, used to decouple the packet stream.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       cnt_reg;
    logic [1:0]       cnt_next;
    logic             ready_reg;
    logic             push;
    logic             pop;

    assign push      = in_valid & ready_reg;
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_reg;
    assign out_valid = (cnt_reg != 2'd0);
    assign out_data  = mem_reg[rd_ptr_reg];

    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + 2'd1;
        end else if (pop && !push) begin
            cnt_next = cnt_reg - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
            ready_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            cnt_reg   <= cnt_next;
            ready_reg <= (cnt_next != 2'd2);
        end
    end

endmodule

// File: rtl/network_run_source.sv
// Replays one stream packet into the network as clear + charge cycle + R zero-charge cycles.
// Define SOURCE_SKID_EN to place a 2-entry skid buffer in front of the packet input.
module network_run_source
    import network_run_source_pkg::*;
#(
    parameter int NUM_INP      = DEF_NUM_INP,
    parameter int CHARGE_WIDTH = DEF_CHARGE_WIDTH,
    parameter int RUN_WIDTH    = DEF_RUN_WIDTH,
    parameter int PKT_WIDTH    = NUM_FLG + RUN_WIDTH + NUM_INP * CHARGE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           src_valid,
    output logic                           src_ready,
    input  logic [PKT_WIDTH-1:0]           src,
    input  logic                           net_ready,
    output logic                           lnk_valid,
    output logic                           net_sync,
    output logic                           net_rst,
    output logic                           net_en,
    output logic signed [CHARGE_WIDTH-1:0] net_inp [NUM_INP]
);

    localparam int SPK_W   = NUM_INP * CHARGE_WIDTH;
    localparam int RUN_LSB = SPK_W;
    localparam int FLG_LSB = SPK_W + RUN_WIDTH;

    state_t                 state_reg;
    state_t                 state_next;
    logic [RUN_WIDTH-1:0]   cnt_reg;
    logic [RUN_WIDTH-1:0]   cnt_next;
    logic [NUM_FLG-1:0]     flg_reg;
    logic [RUN_WIDTH-1:0]   run_reg;
    logic [SPK_W-1:0]       chg_reg;

    logic                   head_valid;
    logic [PKT_WIDTH-1:0]   head_data;
    logic [NUM_FLG-1:0]     head_flg;
    logic                   core_ready;
    logic                   accept;
    logic                   in_run;
    logic                   last;

`ifdef SOURCE_SKID_EN
    stream_skid_buffer #(
        .WIDTH (PKT_WIDTH)
    ) u_skid (
        .clk       (clk),
        .srst      (rst),
        .in_valid  (src_valid),
        .in_ready  (src_ready),
        .in_data   (src),
        .out_valid (head_valid),
        .out_ready (core_ready),
        .out_data  (head_data)
    );
`else
    assign head_valid = src_valid;
    assign head_data  = src;
    assign src_ready  = core_ready;
`endif

    assign head_flg = head_data[FLG_LSB +: NUM_FLG];

    // Outputs are forced idle while rst is high, even before the state register clears.
    assign in_run     = ~rst & ((state_reg == RUN_FIRST) | (state_reg == RUN_REST));
    assign net_en     = in_run & net_ready;
    assign lnk_valid  = net_en;
    assign last       = net_en & ((state_reg == RUN_FIRST) ? (run_reg == '0)
                                                           : (cnt_reg == RUN_WIDTH'(1)));
    assign net_sync   = last & flg_reg[FLG_SNC];
    assign net_rst    = rst | (state_reg == CLEAR);
    assign core_ready = ~rst & ((state_reg == IDLE) | last);
    assign accept     = head_valid & core_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INP; gi++) begin : g_inp
            assign net_inp[gi] = (~rst && state_reg == RUN_FIRST)
                ? $signed(chg_reg[(NUM_INP-1-gi)*CHARGE_WIDTH +: CHARGE_WIDTH])
                : '0;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: ;
            CLEAR: state_next = RUN_FIRST;
            RUN_FIRST: begin
                if (net_ready) begin
                    if (run_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = run_reg;
                        state_next = RUN_REST;
                    end
                end
            end
            RUN_REST: begin
                if (net_ready) begin
                    cnt_next = cnt_reg - RUN_WIDTH'(1);
                    if (cnt_reg == RUN_WIDTH'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Accept only happens in IDLE or on the last enabled cycle, so it may override.
        if (accept) begin
            state_next = head_flg[FLG_CLR] ? CLEAR : RUN_FIRST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            flg_reg   <= '0;
            run_reg   <= '0;
            chg_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                flg_reg <= head_flg;
                run_reg <= head_data[RUN_LSB +: RUN_WIDTH];
                chg_reg <= head_data[SPK_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_network_run_source.sv
// Self-checking bench for network_run_source: directed scenarios plus a randomized event scoreboard.
module tb_network_run_source;
    import network_run_source_pkg::*;

    localparam int NI = 2;
    localparam int CW = 8;
    localparam int RW = 16;
    localparam int PW = NUM_FLG + RW + NI * CW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 src_valid;
    logic                 src_ready;
    logic [PW-1:0]        src;
    logic                 net_ready;
    logic                 lnk_valid;
    logic                 net_sync;
    logic                 net_rst;
    logic                 net_en;
    logic signed [CW-1:0] net_inp [NI];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit                   clr;
        bit                   snc;
        int                   run;
        logic signed [CW-1:0] c0;
        logic signed [CW-1:0] c1;
    } pkt_t;

    typedef struct {
        bit                   is_clr;
        bit                   sync;
        logic signed [CW-1:0] i0;
        logic signed [CW-1:0] i1;
    } ev_t;

    ev_t exp_q[$];

    network_run_source #(
        .NUM_INP      (NI),
        .CHARGE_WIDTH (CW),
        .RUN_WIDTH    (RW),
        .PKT_WIDTH    (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src       (src),
        .net_ready (net_ready),
        .lnk_valid (lnk_valid),
        .net_sync  (net_sync),
        .net_rst   (net_rst),
        .net_en    (net_en),
        .net_inp   (net_inp)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pack(bit clr, bit snc, int run,
                                           logic signed [CW-1:0] c0, logic signed [CW-1:0] c1);
        logic [NUM_FLG-1:0] f;
        f          = '0;
        f[FLG_CLR] = clr;
        f[FLG_SNC] = snc;
        return {f, RW'(run), c0, c1};
    endfunction

    // Model: a packet becomes an optional clear event then R+1 enabled events.
    function automatic void model_push(pkt_t p);
        ev_t e;
        if (p.clr) begin
            e = '{is_clr: 1'b1, sync: 1'b0, i0: '0, i1: '0};
            exp_q.push_back(e);
        end
        for (int k = 0; k <= p.run; k++) begin
            e.is_clr = 1'b0;
            e.sync   = (k == p.run) ? p.snc : 1'b0;
            e.i0     = (k == 0) ? p.c0 : '0;
            e.i1     = (k == 0) ? p.c1 : '0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; src_valid = 1'b1; net_ready = 1'b1; src = pack(0, 0, 0, 8'sd1, 8'sd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if (src_ready !== 1'b0 || net_en !== 1'b0 || net_rst !== 1'b1 || net_inp[0] !== 8'sd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d src_ready=%b net_en=%b net_rst=%b inp0=%0d want 0/0/1/0",
                         k, src_ready, net_en, net_rst, net_inp[0]);
            end
        end
        @(negedge clk); rst = 1'b0; src_valid = 1'b0; #1;
        checks++;
        if (src_ready !== 1'b1 || net_rst !== 1'b0 || net_en !== 1'b0 || lnk_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release src_ready=%b net_rst=%b net_en=%b lnk_valid=%b want 1/0/0/0",
                     src_ready, net_rst, net_en, lnk_valid);
        end
    endtask

    task automatic test_clr_packet();
        @(negedge clk); net_ready = 1'b1; src_valid = 1'b1; src = pack(1, 0, 0, 8'sd3, -8'sd2); #1;
        checks++;
        if (src_ready !== 1'b1) begin
            failures++; $display("FAIL clr_accept src_ready=%b want 1", src_ready);
        end
        @(negedge clk); src_valid = 1'b0; #1;
        checks++;
        if (net_rst !== 1'b1 || net_en !== 1'b0) begin
            failures++; $display("FAIL clr_pulse net_rst=%b net_en=%b want 1/0", net_rst, net_en);
        end
        @(negedge clk); #1;
        checks++;
        if (net_en !== 1'b1 || net_inp[0] !== 8'sd3 || net_inp[1] !== -8'sd2 || net_sync !== 1'b0
            || net_rst !== 1'b0 || src_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_charge net_en=%b inp=%0d,%0d sync=%b net_rst=%b src_ready=%b want 1 3,-2 0 0 1",
                     net_en, net_inp[0], net_inp[1], net_sync, net_rst, src_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (net_en !== 1'b0 || net_rst !== 1'b0 || src_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_idle net_en=%b net_rst=%b src_ready=%b want 0/0/1", net_en, net_rst, src_ready);
        end
    endtask

    task automatic test_run_sync();
        logic signed [CW-1:0] e_in;
        @(negedge clk); net_ready = 1'b1; src_valid = 1'b1; src = pack(0, 1, 3, 8'sd5, 8'sd5); #1;
        checks++;
        if (src_ready !== 1'b1) begin
            failures++; $display("FAIL run_accept src_ready=%b want 1", src_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); src_valid = 1'b0; #1;
            e_in = (k == 0) ? 8'sd5 : 8'sd0;
            checks++;
            if (net_en !== (k < 4) || net_sync !== (k == 3) || net_inp[0] !== e_in || net_inp[1] !== e_in
                || lnk_valid !== net_en) begin
                failures++;
                $display("FAIL run_cycle k=%0d net_en=%b sync=%b inp=%0d,%0d lnk=%b want %b %b %0d,%0d",
                         k, net_en, net_sync, net_inp[0], net_inp[1], lnk_valid, (k < 4), (k == 3), e_in, e_in);
            end
        end
    endtask

    task automatic test_stall();
        bit rdy_pat [7] = '{1, 1, 0, 0, 1, 1, 1};
        bit en_pat  [7] = '{1, 1, 0, 0, 1, 1, 0};
        int n_en = 0;
        @(negedge clk); net_ready = 1'b1; src_valid = 1'b1; src = pack(0, 1, 3, 8'sd5, 8'sd5); #1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); src_valid = 1'b0; net_ready = rdy_pat[k]; #1;
            if (net_en === 1'b1) n_en++;
            checks++;
            if (net_en !== en_pat[k] || net_sync !== (k == 5) || net_inp[0] !== ((k == 0) ? 8'sd5 : 8'sd0)) begin
                failures++;
                $display("FAIL stall_cycle k=%0d net_en=%b sync=%b inp0=%0d want %b %b", k, net_en, net_sync,
                         net_inp[0], en_pat[k], (k == 5));
            end
        end
        checks++;
        if (n_en != 4) begin
            failures++; $display("FAIL stall_count enabled=%0d want 4", n_en);
        end
    endtask

    task automatic test_back_to_back();
        bit                   r_pat [5] = '{0, 1, 0, 1, 1};
        bit                   e_pat [5] = '{1, 1, 1, 1, 0};
        bit                   s_pat [5] = '{0, 0, 0, 1, 0};
        logic signed [CW-1:0] i0_pat [5] = '{8'sd1, 8'sd0, 8'sd7, 8'sd0, 8'sd0};
        logic signed [CW-1:0] i1_pat [5] = '{8'sd2, 8'sd0, -8'sd7, 8'sd0, 8'sd0};
        @(negedge clk); net_ready = 1'b1; src_valid = 1'b1; src = pack(0, 0, 1, 8'sd1, 8'sd2); #1;
        checks++;
        if (src_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_accept_a src_ready=%b want 1", src_ready);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            src_valid = (k < 2);
            src       = pack(0, 1, 1, 8'sd7, -8'sd7);
            #1;
            checks++;
            if (net_en !== e_pat[k] || src_ready !== r_pat[k] || net_sync !== s_pat[k]
                || net_inp[0] !== i0_pat[k] || net_inp[1] !== i1_pat[k]) begin
                failures++;
                $display("FAIL b2b_cycle k=%0d net_en=%b src_ready=%b sync=%b inp=%0d,%0d want %b %b %b %0d,%0d",
                         k, net_en, src_ready, net_sync, net_inp[0], net_inp[1],
                         e_pat[k], r_pat[k], s_pat[k], i0_pat[k], i1_pat[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk); net_ready = 1'b1; src_valid = 1'b1; src = pack(0, 1, 8, 8'sd4, 8'sd4); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); src_valid = 1'b0; #1;
            checks++;
            if (net_en !== 1'b1) begin
                failures++; $display("FAIL midrun_pre k=%0d net_en=%b want 1", k, net_en);
            end
        end
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if (net_rst !== 1'b1 || net_en !== 1'b0 || src_ready !== 1'b0 || net_sync !== 1'b0) begin
            failures++;
            $display("FAIL midrun_rst net_rst=%b net_en=%b src_ready=%b sync=%b want 1/0/0/0",
                     net_rst, net_en, src_ready, net_sync);
        end
        @(negedge clk); rst = 1'b0; #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            checks++;
            if (net_en !== 1'b0 || net_rst !== 1'b0 || src_ready !== 1'b1) begin
                failures++;
                $display("FAIL midrun_after k=%0d net_en=%b net_rst=%b src_ready=%b want 0/0/1",
                         k, net_en, net_rst, src_ready);
            end
        end
        test_run_sync();
    endtask

    task automatic test_random();
        pkt_t p;
        pkt_t pend[$];
        ev_t  e;
        int   cyc = 0;
        exp_q.delete();
        for (int n = 0; n < 14; n++) begin
            p.clr = ($urandom_range(0, 2) == 0);
            p.snc = $urandom_range(0, 1);
            p.run = $urandom_range(0, 5);
            p.c0  = CW'($urandom);
            p.c1  = CW'($urandom);
            pend.push_back(p);
            model_push(p);
        end
        while ((pend.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            net_ready = ($urandom_range(0, 3) != 0);
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                src_valid = 1'b1;
                src       = pack(pend[0].clr, pend[0].snc, pend[0].run, pend[0].c0, pend[0].c1);
            end else begin
                src_valid = 1'b0;
                src       = PW'({$urandom, $urandom});
            end
            #1;
            checks++;
            if (lnk_valid !== net_en || (net_en === 1'b1 && net_ready !== 1'b1)
                || (net_en !== 1'b1 && net_sync !== 1'b0)) begin
                failures++;
                $display("FAIL rnd_handshake cyc=%0d net_en=%b lnk=%b net_ready=%b sync=%b",
                         cyc, net_en, lnk_valid, net_ready, net_sync);
            end
            if (net_rst === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_clr || net_en !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_clear cyc=%0d unexpected net_rst net_en=%b pending=%0d", cyc, net_en, exp_q.size());
                end else begin
                    void'(exp_q.pop_front());
                end
            end else if (net_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_clr) begin
                    failures++;
                    $display("FAIL rnd_enable cyc=%0d unexpected net_en pending=%0d", cyc, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (net_inp[0] !== e.i0 || net_inp[1] !== e.i1 || net_sync !== e.sync) begin
                        failures++;
                        $display("FAIL rnd_data cyc=%0d inp=%0d,%0d sync=%b want %0d,%0d %b",
                                 cyc, net_inp[0], net_inp[1], net_sync, e.i0, e.i1, e.sync);
                    end
                end
            end
            if (src_valid && src_ready === 1'b1) begin
                void'(pend.pop_front());
            end
            cyc++;
        end
        checks++;
        if (cyc >= 4000) begin
            failures++;
            $display("FAIL rnd_timeout packets_left=%0d events_left=%0d want 0/0", pend.size(), exp_q.size());
        end
        @(negedge clk); src_valid = 1'b0; net_ready = 1'b1; #1;
        checks++;
        if (net_en !== 1'b0 || net_rst !== 1'b0 || src_ready !== 1'b1) begin
            failures++;
            $display("FAIL rnd_idle net_en=%b net_rst=%b src_ready=%b want 0/0/1", net_en, net_rst, src_ready);
        end
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = 1'b0;
        net_ready = 1'b0;
        src       = '0;
        test_reset();
        test_clr_packet();
        test_run_sync();
        test_stall();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
